// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MIPS multiply/divide unit with HI/LO registers.
// Multiply has a fixed latency; divide is a 32-step restoring shift-subtract.
module muldiv_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int WIDTH    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2((WIDTH > MULT_LAT) ? WIDTH : MULT_LAT) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV_IT, DIV_FIX} state_t;
  state_t               r_state;
  logic                 r_busy;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_prod;
  logic [WIDTH-1:0]     r_rem, r_quo, r_dvs, r_hi, r_lo;
  logic                 r_qs, r_rs;
  logic signed [2*WIDTH-1:0] w_sprod;
  logic [2*WIDTH-1:0]   w_uprod;
  logic [WIDTH-1:0]     w_abs_a, w_abs_b;
  logic [WIDTH:0]       w_rsh;
  logic [WIDTH+1:0]     w_diff;
  logic                 w_ge;
  always_comb begin
    w_sprod = $signed(a) * $signed(b);
    w_uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    w_abs_a = a[WIDTH-1] ? -a : a;
    w_abs_b = b[WIDTH-1] ? -b : b;
    w_rsh   = {r_rem, r_quo[WIDTH-1]};
    w_diff  = {1'b0, w_rsh} - {2'b0, r_dvs};
    w_ge    = ~w_diff[WIDTH+1];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_qs    <= 1'b0;
      r_rs    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          case (op)
            3'd0, 3'd1: begin
              r_prod  <= op[0] ? w_uprod : w_sprod;
              r_cnt   <= CW'(MULT_LAT - 1);
              r_state <= MUL;
              r_busy  <= 1'b1;
            end
            3'd2, 3'd3: begin
              r_quo   <= op[0] ? a : w_abs_a;
              r_dvs   <= op[0] ? b : w_abs_b;
              r_qs    <= ~op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
              r_rs    <= ~op[0] & a[WIDTH-1];
              r_rem   <= '0;
              r_cnt   <= CW'(WIDTH - 1);
              r_state <= DIV_IT;
              r_busy  <= 1'b1;
            end
            3'd4: r_hi <= a;
            3'd5: r_lo <= a;
            default: ;
          endcase
        end
        MUL: if (r_cnt == '0) begin
          {r_hi, r_lo} <= r_prod;
          r_state      <= IDLE;
          r_busy       <= 1'b0;
        end else r_cnt <= r_cnt - 1'b1;
        DIV_IT: begin
          // A zero divisor always "fits", yielding all-ones quotient and rem=|a|.
          r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_rsh[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          if (r_cnt == '0) r_state <= DIV_FIX;
          else r_cnt <= r_cnt - 1'b1;
        end
        DIV_FIX: begin
          r_lo    <= r_qs ? -r_quo : r_quo;
          r_hi    <= r_rs ? -r_rem : r_rem;
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide unit with HI/LO result registers, serving the MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO instructions in the pipelined core.
- Runs division as a sequenced 32-iteration restoring shift-subtract instead of a single-cycle combinational divide.
- Multiplication uses a fixed, parameterised latency.
- Raises busy so the hazard unit can stall any later MF/MT/mul/div instruction.

Parameters:
- MULT_LAT, 5, busy cycles for MULT/MULTU (minimum 1).
- WIDTH, 32, operand and HI/LO width; divide iterations = WIDTH.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle operation request, sampled on the rising edge.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op.
- a  in  WIDTH  rs operand: dividend, multiplicand, or MT data.
- b  in  WIDTH  rt operand: divisor or multiplier.
- busy  out  1  high while a mult/div is in progress.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, hi=0, lo=0, iteration counter=0, internal shift registers=0. Reset during a mult/div aborts it and writes no result.
- States:
  - IDLE
  - MUL: counts MULT_LAT cycles.
  - DIV_IT: WIDTH iterations, one per cycle.
  - DIV_FIX: sign correction and HI/LO write.
  - busy=1 exactly when state != IDLE. busy is a registered output.
- Acceptance:
  - start is honoured only in IDLE.
  - start while busy is ignored: no queueing, no effect on the running op. The hazard unit guarantees this does not occur; the bench still checks it.
- MTHI/MTLO: in IDLE with start, hi<=a (MTHI) or lo<=a (MTLO) at that edge. State stays IDLE and busy stays 0.
- MULT/MULTU:
  - At acceptance: latch the full 2*WIDTH product, signed for MULT and unsigned for MULTU, into a holding register. Move to MUL with counter=MULT_LAT-1.
  - Each cycle in MUL the counter decrements. When it reaches 0: {hi,lo}<=product and state<=IDLE.
  - busy is high for exactly MULT_LAT cycles. New hi/lo are visible in the cycle busy first reads 0.
- DIV/DIVU:
  - At acceptance: latch the dividend and divisor magnitudes. Signed (DIV): absolute value of each operand. Unsigned (DIVU): raw operands.
  - Also latch quotient-sign = a[31]^b[31] and remainder-sign = a[31] (both forced to 0 for DIVU).
  - Clear the partial remainder, set counter=WIDTH-1, and enter DIV_IT.
  - Each DIV_IT cycle: shift {rem,quo} left by 1 and trial-subtract the divisor. If the result is non-negative, keep it and set the quotient LSB=1.
  - After the counter=0 iteration: enter DIV_FIX. There, negate quo and/or rem per the latched signs, write lo<=quotient and hi<=remainder, and go to IDLE.
  - busy is high for WIDTH+1 = 33 cycles.
- Arithmetic rules:
  - Negation is two's complement modulo 2^WIDTH.
  - -2^31 / -1 gives lo=0x80000000, hi=0.
  - Divide by zero is not special-cased: the natural algorithm gives lo=0xFFFFFFFF, hi=|a|. For signed DIV, the sign fix is then applied. Latency is unchanged.
- hi/lo hold their previous values throughout any busy period. Operand inputs are don't-care after the acceptance edge.
- Back-to-back operations: a start in the first cycle busy=0 is accepted.

Test Plan:
- Reset, then MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 → hi=0x12345678, lo=0x9ABCDEF0, busy never asserted.
- MULT a=0xFFFFFFFE (-2), b=3 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 → busy 33 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=2 → lo=3, hi=1.
- Boundaries:
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU 100 / 0 → lo=0xFFFFFFFF, hi=100, 33 busy cycles.
- Start DIVU 10/3, then assert start with MTLO a=0xDEAD at busy cycle 4 → ignored. Final lo=3, hi=1, and lo never shows 0xDEAD.
- Start DIV, then drive reset low at busy cycle 10 → busy=0, hi=lo=0 immediately, without waiting for a clock edge. After release, MULTU 6*7 → lo=42, hi=0.
